// File: rtl/gsim_pkg.sv
// Shared definitions for the GSIM stream I/O block: FSM states, mode codes,
// and beat-count helpers so every file derives the same geometry.
package gsim_pkg;

    localparam int unsigned DEF_N      = 8;
    localparam int unsigned DEF_IN_W   = 16;
    localparam int unsigned DEF_ELEM_W = 8;
    localparam int unsigned DEF_RES_W  = 32;
    localparam int unsigned DEF_OUT_W  = 8;

    localparam logic MODE_SOLVE = 1'b0;
    localparam logic MODE_INV   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT_RES,
        S_DRAIN,
        S_DONE
    } gsim_state_t;

    function automatic int unsigned calc_epc(input int unsigned in_w, input int unsigned elem_w);
        return in_w / elem_w;
    endfunction

    function automatic int unsigned calc_bpr(input int unsigned res_w, input int unsigned out_w);
        return res_w / out_w;
    endfunction

    localparam int unsigned EPC     = calc_epc(DEF_IN_W, DEF_ELEM_W);
    localparam int unsigned A_BEATS = DEF_N * DEF_N / EPC;
    localparam int unsigned B_BEATS = DEF_N / EPC;
    localparam int unsigned BPR     = calc_bpr(DEF_RES_W, DEF_OUT_W);

endpackage

// File: rtl/gsim_out_serializer.sv
// Streams buffered core results out as OUT_W beats, result 0 first and the
// most significant slice of each result first.
module gsim_out_serializer
    import gsim_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned RES_W = DEF_RES_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    go,
    input  logic [((N*N > 1) ? $clog2(N*N) : 1)-1:0] last_idx,
    input  logic [RES_W-1:0]                        rd_data,
    output logic [((N*N > 1) ? $clog2(N*N) : 1)-1:0] rd_idx,
    output logic                                    out_valid,
    output logic [OUT_W-1:0]                        data_o,
    output logic                                    last_beat
);

    localparam int unsigned L_BPR = calc_bpr(RES_W, OUT_W);
    localparam int unsigned IW    = (N*N > 1) ? $clog2(N*N) : 1;
    localparam int unsigned SW    = (L_BPR > 1) ? $clog2(L_BPR) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(L_BPR - 1);

    logic [SW-1:0] sub;
    logic [IW-1:0] idx;

    assign rd_idx    = idx;
    assign last_beat = out_valid && (idx == last_idx) && (sub == SUB_LAST);

    // Gated by out_valid so an asynchronous reset forces data_o to zero at once.
    always_comb begin
        data_o = '0;
        if (out_valid) begin
            for (int unsigned s = 0; s < L_BPR; s++) begin
                if (sub == SW'(s)) begin
                    data_o = rd_data[(L_BPR-1-s)*OUT_W +: OUT_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            idx       <= '0;
            sub       <= '0;
        end else if (go) begin
            out_valid <= 1'b1;
            idx       <= '0;
            sub       <= '0;
        end else if (out_valid) begin
            if (sub == SUB_LAST) begin
                sub <= '0;
                if (idx == last_idx) begin
                    out_valid <= 1'b0;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                sub <= sub + SW'(1);
            end
        end
    end

endmodule

// File: rtl/gsim_stream_io.sv
// GSIM solver I/O: deserialises A (and b) from the input stream, hands them
// to the core, buffers the core's results and streams them back out.
module gsim_stream_io
    import gsim_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned IN_W   = DEF_IN_W,
    parameter int unsigned ELEM_W = DEF_ELEM_W,
    parameter int unsigned RES_W  = DEF_RES_W,
    parameter int unsigned OUT_W  = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_en,
    input  logic                    mode,
    input  logic [IN_W-1:0]         data_i,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        data_o,
    output logic [N*N*ELEM_W-1:0]   a_flat,
    output logic [N*ELEM_W-1:0]     b_flat,
    output logic                    core_mode,
    output logic                    start,
    input  logic                    res_valid,
    input  logic [RES_W-1:0]        res_data,
    output logic                    res_ready,
    output logic                    frame_err
);

    localparam int unsigned L_EPC     = calc_epc(IN_W, ELEM_W);
    localparam int unsigned L_A_BEATS = N * N / L_EPC;
    localparam int unsigned L_B_BEATS = N / L_EPC;
    localparam int unsigned BW        = $clog2(L_A_BEATS + L_B_BEATS + 1);
    localparam int unsigned IW        = (N*N > 1) ? $clog2(N*N) : 1;
    localparam logic [BW-1:0] A_LAST  = BW'(L_A_BEATS - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(L_A_BEATS + L_B_BEATS - 1);

    gsim_state_t    state;
    logic [BW-1:0]  beat_cnt;
    logic [IW-1:0]  res_cnt;
    logic [IW-1:0]  nres_last;
    logic [RES_W-1:0] res_buf [N*N];
    logic [IW-1:0]  rd_idx;
    logic           go;
    logic           ser_last;

    assign nres_last = (core_mode == MODE_INV) ? IW'(N*N - 1) : IW'(N - 1);
    assign go        = res_ready && res_valid && (res_cnt == nres_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            a_flat    <= '0;
            b_flat    <= '0;
            core_mode <= 1'b0;
            start     <= 1'b0;
            res_ready <= 1'b0;
            frame_err <= 1'b0;
            beat_cnt  <= '0;
            res_cnt   <= '0;
            for (int unsigned i = 0; i < N*N; i++) begin
                res_buf[i] <= '0;
            end
        end else begin
            start     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (in_en) begin
                        a_flat    <= {a_flat[N*N*ELEM_W-IN_W-1:0], data_i};
                        core_mode <= mode;
                        beat_cnt  <= BW'(1);
                        state     <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    if (!in_en) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        a_flat   <= {a_flat[N*N*ELEM_W-IN_W-1:0], data_i};
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_cnt == A_LAST) begin
                            if (core_mode == MODE_INV) begin
                                start <= 1'b1;
                                state <= S_START;
                            end else begin
                                state <= S_LOAD_B;
                            end
                        end
                    end
                end
                S_LOAD_B: begin
                    if (!in_en) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        b_flat   <= {b_flat[N*ELEM_W-IN_W-1:0], data_i};
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_cnt == B_LAST) begin
                            start <= 1'b1;
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    frame_err <= in_en;
                    res_cnt   <= '0;
                    res_ready <= 1'b1;
                    state     <= S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    frame_err <= in_en;
                    if (res_valid) begin
                        res_buf[res_cnt] <= res_data;
                        res_cnt          <= res_cnt + IW'(1);
                        if (res_cnt == nres_last) begin
                            res_ready <= 1'b0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    frame_err <= in_en;
                    if (ser_last) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    gsim_out_serializer #(
        .N     (N),
        .RES_W (RES_W),
        .OUT_W (OUT_W)
    ) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .go        (go),
        .last_idx  (nres_last),
        .rd_data   (res_buf[rd_idx]),
        .rd_idx    (rd_idx),
        .out_valid (out_valid),
        .data_o    (data_o),
        .last_beat (ser_last)
    );

endmodule

// File: tb/tb_gsim_stream_io.sv
// Self-checking bench for gsim_stream_io: a queue-based frame/result model
// checked every cycle, plus hand-computed literal checks per scenario.
module tb_gsim_stream_io;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_en = 1'b0;
    logic         mode = 1'b0;
    logic [15:0]  data_i = '0;
    logic         out_valid;
    logic [7:0]   data_o;
    logic [511:0] a_flat;
    logic [63:0]  b_flat;
    logic         core_mode;
    logic         start;
    logic         res_valid = 1'b0;
    logic [31:0]  res_data = '0;
    logic         res_ready;
    logic         frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gsim_stream_io #(
        .N      (8),
        .IN_W   (16),
        .ELEM_W (8),
        .RES_W  (32),
        .OUT_W  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_en     (in_en),
        .mode      (mode),
        .data_i    (data_i),
        .out_valid (out_valid),
        .data_o    (data_o),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .core_mode (core_mode),
        .start     (start),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .frame_err (frame_err)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model state: what the outputs must be in the current cycle.
    bit          m_loading, m_start, m_err, m_accept, m_mode;
    int          m_cnt, m_need, m_got, m_nres, m_drain;
    logic [7:0]  m_a [64];
    logic [7:0]  m_b [8];
    logic [7:0]  m_beats [$];
    logic [7:0]  cap [$];

    task automatic model_reset();
        m_loading = 0; m_start = 0; m_err = 0; m_accept = 0; m_mode = 0;
        m_cnt = 0; m_need = 0; m_got = 0; m_nres = 0; m_drain = 0;
        for (int k = 0; k < 64; k++) m_a[k] = '0;
        for (int k = 0; k < 8; k++) m_b[k] = '0;
        m_beats.delete();
    endtask

    task automatic model_store(input int beat);
        for (int p = 0; p < 2; p++) begin
            int e;
            e = beat * 2 + p;
            if (e < 64) m_a[e] = data_i[(1-p)*8 +: 8];
            else        m_b[e-64] = data_i[(1-p)*8 +: 8];
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ctrl", {out_valid, start, res_ready, frame_err, core_mode, data_o}, '0);
            chk("rst_a", a_flat, '0);
            chk("rst_b", b_flat, '0);
            model_reset();
        end else begin
            logic [511:0] ea;
            logic [63:0]  eb;
            bit busy, n_start, n_err;
            chk("start", start, m_start);
            chk("frame_err", frame_err, m_err);
            chk("res_ready", res_ready, m_accept);
            chk("out_valid", out_valid, m_drain > 0);
            chk("data_o", data_o, (m_drain > 0) ? m_beats[0] : 8'h00);
            if (out_valid) cap.push_back(data_o);
            if (m_start) begin
                for (int k = 0; k < 64; k++) ea[(63-k)*8 +: 8] = m_a[k];
                for (int k = 0; k < 8; k++)  eb[(7-k)*8 +: 8] = m_b[k];
                chk("a_flat", a_flat, ea);
                chk("b_flat", b_flat, {448'b0, eb});
                chk("core_mode", core_mode, m_mode);
            end
            // Advance the model with the inputs the next edge will sample.
            busy = m_start || m_accept || (m_drain > 0);
            n_start = 0; n_err = 0;
            if (m_drain > 0) begin
                void'(m_beats.pop_front());
                m_drain--;
            end
            if (in_en && busy) begin
                n_err = 1;
            end else if (m_loading) begin
                if (in_en) begin
                    model_store(m_cnt);
                    m_cnt++;
                    if (m_cnt == m_need) begin
                        m_loading = 0;
                        n_start = 1;
                    end
                end else begin
                    n_err = 1;
                    m_loading = 0;
                end
            end else if (in_en) begin
                m_loading = 1;
                m_mode = mode;
                m_need = mode ? 32 : 36;
                model_store(0);
                m_cnt = 1;
            end
            if (m_accept && res_valid) begin
                for (int s = 0; s < 4; s++) m_beats.push_back(res_data[(3-s)*8 +: 8]);
                m_got++;
                if (m_got == m_nres) begin
                    m_accept = 0;
                    m_drain = m_nres * 4;
                end
            end
            if (m_start) begin
                m_accept = 1;
                m_got = 0;
                m_nres = m_mode ? 64 : 8;
            end
            m_start = n_start;
            m_err = n_err;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Beat j carries elements 2j (high byte) and 2j+1; A[k]=aoff+k, b[i]=boff+i.
    task automatic send_frame(input logic md, input int nbeats, input logic [7:0] aoff, input logic [7:0] boff);
        for (int j = 0; j < nbeats; j++) begin
            logic [7:0] v [2];
            for (int p = 0; p < 2; p++) begin
                int e;
                e = 2 * j + p;
                v[p] = (e < 64) ? 8'(aoff + 8'(e)) : 8'(boff + 8'(e - 64));
            end
            in_en  = 1'b1;
            mode   = (j == 0) ? md : ~md;
            data_i = {v[0], v[1]};
            tick();
        end
        in_en = 1'b0;
        mode  = 1'b0;
    endtask

    function automatic logic [31:0] res_val(input int kind, input int i);
        case (kind)
            0:       return 32'h11111111 * 32'(i + 1);
            1:       return 32'(i);
            default: return 32'h10203040 + 32'h01010101 * 32'(i);
        endcase
    endfunction

    task automatic send_results(input int first, input int count, input int kind, input bit bubble);
        for (int i = first; i < first + count; i++) begin
            res_valid = 1'b1;
            res_data  = res_val(kind, i);
            tick();
            res_valid = 1'b0;
            res_data  = 32'hDEADBEEF;
            if (bubble) tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick();

        // 1: mode 0 load, A[k]=k, b[i]=0x80+i
        send_frame(1'b0, 36, 8'h00, 8'h80);
        chk("t1_start_after_beat35", start, 1'b1);
        chk("t1_a_top", a_flat[511:504], 8'h00);
        chk("t1_a_low", a_flat[7:0], 8'h3F);
        chk("t1_b_low", b_flat[7:0], 8'h87);
        tick();
        chk("t1_start_one_cycle", start, 1'b0);

        // 2: mode 0 results with bubbles
        cap.delete();
        send_results(0, 8, 0, 1'b1);
        tick(40);
        chk("t2_beats", cap.size(), 32);
        chk("t2_beat0", cap[0], 8'h11);
        chk("t2_beat3", cap[3], 8'h11);
        chk("t2_beat4", cap[4], 8'h22);
        chk("t2_beat31", cap[31], 8'h88);
        chk("t2_ov_low", out_valid, 1'b0);

        // 3: mode 1 load, LOAD_B skipped, b_flat untouched
        send_frame(1'b1, 32, 8'h40, 8'h00);
        chk("t3_start_after_beat31", start, 1'b1);
        chk("t3_core_mode", core_mode, 1'b1);
        chk("t3_b_kept", b_flat[7:0], 8'h87);
        tick();
        cap.delete();
        send_results(0, 64, 1, 1'b0);
        tick(262);
        chk("t3_beats", cap.size(), 256);
        chk("t3_beat3", cap[3], 8'h00);
        chk("t3_beat7", cap[7], 8'h01);
        chk("t3_beat255", cap[255], 8'h3F);

        // 4: in_en drops at beat 10, then a full frame
        send_frame(1'b0, 10, 8'h00, 8'h00);
        tick();
        chk("t4_err_pulse", frame_err, 1'b1);
        tick();
        chk("t4_err_once", frame_err, 1'b0);
        tick(3);
        send_frame(1'b0, 36, 8'h60, 8'h90);
        chk("t4_start", start, 1'b1);
        chk("t4_b_low", b_flat[7:0], 8'h97);
        tick();
        cap.delete();
        send_results(0, 8, 2, 1'b0);
        tick(36);
        chk("t4_beats", cap.size(), 32);
        chk("t4_beat0", cap[0], 8'h10);

        // 5: reset mid-drain
        send_frame(1'b0, 36, 8'h20, 8'h30);
        tick();
        send_results(0, 8, 2, 1'b0);
        tick(5);
        chk("t5_beat5_valid", out_valid, 1'b1);
        chk("t5_beat5_data", data_o, 8'h21);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_ov", out_valid, 1'b0);
        chk("t5_async_data", data_o, 8'h00);
        tick(2);
        reset_n = 1'b1;
        chk("t5_res_ready", res_ready, 1'b0);
        tick();

        // 6: res_valid during load, in_en during WAIT_RES
        res_valid = 1'b1;
        res_data  = 32'hBAD0BAD0;
        send_frame(1'b0, 36, 8'h05, 8'hA0);
        res_valid = 1'b0;
        chk("t6_start", start, 1'b1);
        chk("t6_no_ready", res_ready, 1'b0);
        tick();
        cap.delete();
        send_results(0, 4, 1, 1'b1);
        in_en = 1'b1;
        tick();
        in_en = 1'b0;
        chk("t6_err_pulse", frame_err, 1'b1);
        send_results(4, 4, 1, 1'b1);
        tick(36);
        chk("t6_beats", cap.size(), 32);
        chk("t6_beat3", cap[3], 8'h00);
        chk("t6_beat31", cap[31], 8'h07);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
